// File: rtl/output_layer_mac_pkg.sv
// Shared constants, default widths and FSM state encoding for the output-layer MAC.
// Optional argmax stage is controlled by macro OUTPUT_LAYER_ARGMAX_EN.
package elm_pkg;

  localparam int ELM_IDX_W        = 13;
  localparam int ELM_CLS_W        = 6;
  localparam int ELM_N_OUT_DEF    = 10;
  localparam int ELM_N_HIDDEN_DEF = 3000;
  localparam int ELM_HW_DEF       = 32;
  localparam int ELM_WW_DEF       = 16;
  localparam int ELM_AW_DEF       = 48;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRIME,
    ST_RUN,
    ST_ARGMAX,
    ST_DONE
  } elm_state_t;

endpackage

// File: rtl/output_layer_mac_if.sv
// Bus between the output-layer MAC and its sample source / weight ROM.
// class_idx exists only when OUTPUT_LAYER_ARGMAX_EN is defined.
interface output_layer_mac_if
  import elm_pkg::*;
#(
  parameter int N_OUT = ELM_N_OUT_DEF,
  parameter int HW    = ELM_HW_DEF,
  parameter int WW    = ELM_WW_DEF,
  parameter int AW    = ELM_AW_DEF
);
  logic                  start;
  logic                  h_valid;
  logic signed [HW-1:0]  h_data;
  logic                  h_ready;
  logic [ELM_IDX_W-1:0]  w_addr;
  logic [N_OUT*WW-1:0]   w_data;
  logic [N_OUT*AW-1:0]   acc_out;
  logic                  busy;
  logic                  out_valid;
`ifdef OUTPUT_LAYER_ARGMAX_EN
  logic [ELM_CLS_W-1:0]  class_idx;

  modport master (
    output start, h_valid, h_data, w_data,
    input  h_ready, w_addr, acc_out, busy, out_valid, class_idx
  );
  modport slave (
    input  start, h_valid, h_data, w_data,
    output h_ready, w_addr, acc_out, busy, out_valid, class_idx
  );
`else
  modport master (
    output start, h_valid, h_data, w_data,
    input  h_ready, w_addr, acc_out, busy, out_valid
  );
  modport slave (
    input  start, h_valid, h_data, w_data,
    output h_ready, w_addr, acc_out, busy, out_valid
  );
`endif
endinterface

// File: rtl/output_layer_mac_argmax.sv
// Sequential argmax over the accumulator bank, one channel per cycle, lowest index wins ties.
// Compiled only when OUTPUT_LAYER_ARGMAX_EN is defined.
`ifdef OUTPUT_LAYER_ARGMAX_EN
module elm_argmax_seq
  import elm_pkg::*;
#(
  parameter int N_OUT = ELM_N_OUT_DEF,
  parameter int AW    = ELM_AW_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [N_OUT*AW-1:0]  acc_out,
  output logic [ELM_CLS_W-1:0] idx,
  output logic                 done
);
  // Padded to 64 entries so a 6-bit channel counter indexes it exactly.
  logic signed [AW-1:0]  acc_ch [64];
  logic                  running;
  logic [ELM_CLS_W-1:0]  cnt;
  logic [ELM_CLS_W-1:0]  best_idx;
  logic signed [AW-1:0]  best_val;
  logic                  take;

  for (genvar k = 0; k < 64; k++) begin : g_unpack
    if (k < N_OUT) begin : g_used
      assign acc_ch[k] = acc_out[k*AW +: AW];
    end else begin : g_pad
      assign acc_ch[k] = '0;
    end
  end

  assign take = (cnt == '0) || (acc_ch[cnt] > best_val);
  assign idx  = take ? cnt : best_idx;
  assign done = running && (cnt == ELM_CLS_W'(N_OUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      running <= 1'b0;
      cnt     <= '0;
    end else if (start) begin
      running <= 1'b1;
      cnt     <= '0;
    end else if (running) begin
      if (done) running <= 1'b0;
      else      cnt     <= cnt + ELM_CLS_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (running && take) begin
      best_val <= acc_ch[cnt];
      best_idx <= cnt;
    end
  end
endmodule
`endif

// File: rtl/output_layer_mac.sv
// Output-layer multiply-accumulate: streams hidden samples against ROM weight rows into N_OUT accumulators.
// Define OUTPUT_LAYER_ARGMAX_EN to add a sequential argmax stage and the class_idx output.
module output_layer_mac
  import elm_pkg::*;
#(
  parameter int N_OUT    = ELM_N_OUT_DEF,
  parameter int N_HIDDEN = ELM_N_HIDDEN_DEF,
  parameter int HW       = ELM_HW_DEF,
  parameter int WW       = ELM_WW_DEF,
  parameter int AW       = ELM_AW_DEF
) (
  input  logic             clk,
  input  logic             rst,
  output_layer_mac_if.slave bus
);
  if (AW < HW + WW) begin : g_aw_check
    $error("output_layer_mac: AW must be at least HW+WW");
  end

  elm_state_t            state;
  logic [ELM_IDX_W-1:0]  idx;
  logic                  h_ready_r;
  logic                  busy_r;
  logic                  out_valid_r;
  logic                  start_ok;
  logic                  accept;
  logic                  last;

  // Full-precision product sign-extended into the accumulator width; sums wrap.
  function automatic logic signed [AW-1:0] mac_term(input logic signed [HW-1:0] h,
                                                     input logic signed [WW-1:0] w);
    logic signed [HW+WW-1:0] prod;
    prod = h * w;
    return AW'(prod);
  endfunction

  assign start_ok      = bus.start && (state == ST_IDLE || state == ST_DONE);
  assign accept        = bus.h_valid && h_ready_r;
  assign last          = (idx == ELM_IDX_W'(N_HIDDEN - 1));
  assign bus.h_ready   = h_ready_r;
  assign bus.busy      = busy_r;
  assign bus.out_valid = out_valid_r;

  // Look one row ahead on acceptance so the registered ROM row tracks idx.
  always_comb begin
    bus.w_addr = idx;
    if (start_ok)    bus.w_addr = '0;
    else if (accept) bus.w_addr = idx + ELM_IDX_W'(1);
  end

  // Stage p0: accumulator bank
  for (genvar k = 0; k < N_OUT; k++) begin : g_ch
    logic signed [WW-1:0] w_k;
    logic signed [AW-1:0] acc_p0;

    assign w_k = bus.w_data[k*WW +: WW];
    assign bus.acc_out[k*AW +: AW] = acc_p0;

    always_ff @(posedge clk or posedge rst) begin
      if (rst)           acc_p0 <= '0;
      else if (start_ok) acc_p0 <= '0;
      else if (accept)   acc_p0 <= acc_p0 + mac_term(bus.h_data, w_k);
    end
  end

`ifdef OUTPUT_LAYER_ARGMAX_EN
  logic                 am_done;
  logic [ELM_CLS_W-1:0] am_idx;
  logic [ELM_CLS_W-1:0] class_idx_r;

  assign bus.class_idx = class_idx_r;

  elm_argmax_seq #(.N_OUT(N_OUT), .AW(AW)) u_argmax (
    .clk     (clk),
    .rst     (rst),
    .start   (accept && last),
    .acc_out (bus.acc_out),
    .idx     (am_idx),
    .done    (am_done)
  );
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      idx         <= '0;
      h_ready_r   <= 1'b0;
      busy_r      <= 1'b0;
      out_valid_r <= 1'b0;
`ifdef OUTPUT_LAYER_ARGMAX_EN
      class_idx_r <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            state       <= ST_PRIME;
            idx         <= '0;
            busy_r      <= 1'b1;
            out_valid_r <= 1'b0;
          end
        end
        ST_PRIME: begin
          state     <= ST_RUN;
          h_ready_r <= 1'b1;
        end
        ST_RUN: begin
          if (accept) begin
            idx <= idx + ELM_IDX_W'(1);
            if (last) begin
              h_ready_r <= 1'b0;
`ifdef OUTPUT_LAYER_ARGMAX_EN
              state     <= ST_ARGMAX;
`else
              state       <= ST_DONE;
              busy_r      <= 1'b0;
              out_valid_r <= 1'b1;
`endif
            end
          end
        end
`ifdef OUTPUT_LAYER_ARGMAX_EN
        ST_ARGMAX: begin
          if (am_done) begin
            class_idx_r <= am_idx;
            state       <= ST_DONE;
            busy_r      <= 1'b0;
            out_valid_r <= 1'b1;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_output_layer_mac.sv
// Self-checking bench for output_layer_mac: table vectors on a 4-sample instance, random stream on a 3000-sample one.
// Argmax checks are included when OUTPUT_LAYER_ARGMAX_EN is defined.
module tb_output_layer_mac;
  import elm_pkg::*;

  localparam int NO   = 10;
  localparam int NH_A = 4;
  localparam int NH_B = 3000;
  localparam int HW   = 32;
  localparam int WW   = 16;
  localparam int AW   = 48;

  typedef struct {
    int     h[4];
    int     w[4];
    longint exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  output_layer_mac_if #(.N_OUT(NO), .HW(HW), .WW(WW), .AW(AW)) bus_a ();
  output_layer_mac_if #(.N_OUT(NO), .HW(HW), .WW(WW), .AW(AW)) bus_b ();

  output_layer_mac #(.N_OUT(NO), .N_HIDDEN(NH_A), .HW(HW), .WW(WW), .AW(AW)) dut_a (
    .clk (clk), .rst (rst), .bus (bus_a)
  );
  output_layer_mac #(.N_OUT(NO), .N_HIDDEN(NH_B), .HW(HW), .WW(WW), .AW(AW)) dut_b (
    .clk (clk), .rst (rst), .bus (bus_b)
  );

  logic [NO*WW-1:0] rom_a [0:15];
  logic [NO*WW-1:0] rom_b [0:4095];
  int               hs_b  [NH_B];

  // Registered weight ROMs, one cycle latency.
  always @(posedge clk) begin
    bus_a.w_data <= (bus_a.w_addr < 13'd4)    ? rom_a[bus_a.w_addr[3:0]]  : '0;
    bus_b.w_data <= (bus_b.w_addr < 13'd3000) ? rom_b[bus_b.w_addr[11:0]] : '0;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [AW-1:0] acc_of(input logic [NO*AW-1:0] v, input int k);
    return v[k*AW +: AW];
  endfunction

  task automatic run_a(input int h[4], input int start_at);
    int i = 0;
    int guard = 0;
    bit a;
    bit ov_at_last = 1'b1;
    bus_a.start = 1'b1;
    @(posedge clk); #1;
    bus_a.start = 1'b0;
    chk("a_prime_h_ready", bus_a.h_ready, 0);
    chk("a_prime_out_valid", bus_a.out_valid, 0);
    chk("a_prime_busy", bus_a.busy, 1);
    while (i < NH_A && guard < 100) begin
      bus_a.h_valid = ($urandom_range(0, 2) != 0);
      bus_a.h_data  = bus_a.h_valid ? h[i] : $urandom();
      bus_a.start   = (start_at >= 0 && i == start_at);
      a = bus_a.h_valid && bus_a.h_ready;
      if (a && i == NH_A - 1) ov_at_last = bus_a.out_valid;
      @(posedge clk); #1;
      guard++;
      if (a) i++;
    end
    bus_a.h_valid = 1'b0;
    bus_a.start   = 1'b0;
    chk("a_all_accepted", i, NH_A);
    chk("a_out_valid_low_at_last_accept", ov_at_last, 0);
    chk("a_h_ready_after_last", bus_a.h_ready, 0);
`ifdef OUTPUT_LAYER_ARGMAX_EN
    begin
      int n = 0;
      while (!bus_a.out_valid && n < 64) begin
        @(posedge clk); #1;
        n++;
      end
      chk("a_argmax_latency", n, NO);
    end
`else
    chk("a_out_valid_next_cycle", bus_a.out_valid, 1);
`endif
    chk("a_busy_done", bus_a.busy, 0);
  endtask

  task automatic run_b(input int rst_at);
    int i = 0;
    int guard = 0;
    bit a;
    bus_b.start = 1'b1;
    @(posedge clk); #1;
    bus_b.start = 1'b0;
    chk("b_prime_h_ready", bus_b.h_ready, 0);
    while (i < NH_B && guard < 20000) begin
      if (i == rst_at) begin
        chk("b_busy_before_rst", bus_b.busy, 1);
        bus_b.h_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("b_rst_acc_zero", |bus_b.acc_out, 0);
        chk("b_rst_busy", bus_b.busy, 0);
        chk("b_rst_h_ready", bus_b.h_ready, 0);
        chk("b_rst_out_valid", bus_b.out_valid, 0);
        chk("b_rst_w_addr", bus_b.w_addr, 0);
`ifdef OUTPUT_LAYER_ARGMAX_EN
        chk("b_rst_class_idx", bus_b.class_idx, 0);
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        return;
      end
      bus_b.h_valid = ($urandom_range(0, 3) != 0);
      bus_b.h_data  = bus_b.h_valid ? hs_b[i] : $urandom();
      a = bus_b.h_valid && bus_b.h_ready;
      @(posedge clk); #1;
      guard++;
      if (a) i++;
    end
    bus_b.h_valid = 1'b0;
    chk("b_all_accepted", i, NH_B);
`ifdef OUTPUT_LAYER_ARGMAX_EN
    begin
      int n = 0;
      while (!bus_b.out_valid && n < 64) begin
        @(posedge clk); #1;
        n++;
      end
      chk("b_argmax_latency", n, NO);
    end
`else
    chk("b_out_valid_next_cycle", bus_b.out_valid, 1);
`endif
  endtask

  task automatic fill_b();
    for (int i = 0; i < NH_B; i++) begin
      hs_b[i]  = $urandom();
      rom_b[i] = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    end
    hs_b[0]  = 32'h8000_0000;
    rom_b[0] = {NO{16'h8000}};
  endtask

  // Reference: plain dot product per channel, then truncate to the accumulator width.
  task automatic check_b_model(input string tag);
    logic signed [AW-1:0] m [NO];
    int best = 0;
    for (int k = 0; k < NO; k++) begin
      longint s = 0;
      for (int i = 0; i < NH_B; i++)
        s += longint'(hs_b[i]) * longint'($signed(rom_b[i][k*WW +: WW]));
      m[k] = s[AW-1:0];
      chk($sformatf("%s_acc%0d", tag, k), {16'h0, acc_of(bus_b.acc_out, k)}, {16'h0, m[k]});
    end
    for (int k = 1; k < NO; k++) if (m[k] > m[best]) best = k;
`ifdef OUTPUT_LAYER_ARGMAX_EN
    chk({tag, "_class_idx"}, bus_b.class_idx, best);
`else
    if (best < 0) chk({tag, "_argmax_model"}, best, 0);
`endif
  endtask

  vec_t tbl [6];

  initial begin
    tbl[0].h = '{1, 2, 3, 4};                     tbl[0].w = '{1, 1, 1, 1};
    tbl[0].exp = 64'd10;
    tbl[1].h = '{32'h8000_0000, 0, 0, 0};         tbl[1].w = '{-32768, 0, 0, 0};
    tbl[1].exp = 64'd70368744177664;
    tbl[2].h = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 0, 0}; tbl[2].w = '{32767, 32767, 0, 0};
    tbl[2].exp = 64'd140733193322498;
    tbl[3].h = '{-5, 7, -9, 11};                  tbl[3].w = '{3, -2, 4, -1};
    tbl[3].exp = -76;
    tbl[4].h = '{100, -100, 0, 1};                tbl[4].w = '{-32768, -32768, 5, -1};
    tbl[4].exp = -1;
    tbl[5].h = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
    tbl[5].w = '{-32768, -32768, -32768, -32768};
    tbl[5].exp = 0;

    rst = 1'b1;
    bus_a.start = 1'b0; bus_a.h_valid = 1'b0; bus_a.h_data = '0;
    bus_b.start = 1'b0; bus_b.h_valid = 1'b0; bus_b.h_data = '0;
    for (int i = 0; i < 16; i++) rom_a[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a_acc_zero", |bus_a.acc_out, 0);
    chk("rst_a_busy", bus_a.busy, 0);
    chk("rst_a_h_ready", bus_a.h_ready, 0);
    chk("rst_a_out_valid", bus_a.out_valid, 0);
    chk("rst_a_w_addr", bus_a.w_addr, 0);
`ifdef OUTPUT_LAYER_ARGMAX_EN
    chk("rst_a_class_idx", bus_a.class_idx, 0);
`endif
    rst = 1'b0;
    @(posedge clk); #1;

    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < NH_A; i++)
        for (int k = 0; k < NO; k++) rom_a[i][k*WW +: WW] = 16'(tbl[t].w[i]);
      run_a(tbl[t].h, (t == 0) ? -1 : 1);
      for (int k = 0; k < NO; k++)
        chk($sformatf("vec%0d_acc%0d", t, k), {16'h0, acc_of(bus_a.acc_out, k)},
            {16'h0, tbl[t].exp[AW-1:0]});
`ifdef OUTPUT_LAYER_ARGMAX_EN
      chk($sformatf("vec%0d_class_idx", t), bus_a.class_idx, 0);
`endif
      repeat (3) @(posedge clk);
      #1;
      chk($sformatf("vec%0d_hold_acc0", t), {16'h0, acc_of(bus_a.acc_out, 0)},
          {16'h0, tbl[t].exp[AW-1:0]});
      chk($sformatf("vec%0d_hold_out_valid", t), bus_a.out_valid, 1);
    end

    // Start pulsed during RUN must be ignored.
    for (int i = 0; i < NH_A; i++) rom_a[i] = {NO{16'h0001}};
    run_a(tbl[0].h, 2);
    for (int k = 0; k < NO; k++)
      chk($sformatf("start_in_run_acc%0d", k), {16'h0, acc_of(bus_a.acc_out, k)}, 64'd10);

    // Argmax hand vectors: row 0 carries the channel values, h selects row 0 only.
    begin
      int h1[4] = '{1, 0, 0, 0};
      int va[NO] = '{5, -3, 9, 9, 0, 0, 0, 0, 0, 0};
      int vb[NO] = '{-7, -2, -9, -2, -5, -5, -5, -5, -5, -5};
      for (int i = 1; i < NH_A; i++) rom_a[i] = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      for (int k = 0; k < NO; k++) rom_a[0][k*WW +: WW] = 16'(va[k]);
      run_a(h1, -1);
      for (int k = 0; k < NO; k++)
        chk($sformatf("am1_acc%0d", k), {16'h0, acc_of(bus_a.acc_out, k)},
            {16'h0, 48'(longint'(va[k]))});
`ifdef OUTPUT_LAYER_ARGMAX_EN
      chk("am1_class_idx", bus_a.class_idx, 2);
`endif
      for (int k = 0; k < NO; k++) rom_a[0][k*WW +: WW] = 16'(vb[k]);
      run_a(h1, -1);
      chk("am2_acc1", {16'h0, acc_of(bus_a.acc_out, 1)}, {16'h0, 48'(longint'(-2))});
`ifdef OUTPUT_LAYER_ARGMAX_EN
      chk("am2_class_idx", bus_a.class_idx, 1);
`endif
    end

    fill_b();
    run_b(-1);
    check_b_model("rand1");

    fill_b();
    run_b(1500);
    fill_b();
    run_b(-1);
    check_b_model("after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=%0d required=%0d", 1, 0);
    $fatal(1, "timeout");
  end
endmodule
